// File: rtl/panda_risc_v_pkg.sv
// Shared definitions for the Panda RISC-V execution units: divider FSM encoding and constants.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package panda_risc_v_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_OUT  = 2'd3
    } div_state_e;

    // One restoring step per quotient bit over the 33-bit magnitude
    localparam int DIV_ITER_N = 33;

    // RISC-V defines x/0 as all ones
    localparam logic [31:0] DIV_BY_ZERO_QUO = 32'hFFFF_FFFF;

    // Two's-complement magnitude of a 33-bit signed operand
    function automatic logic [32:0] div_abs33(input logic [32:0] v);
        return v[32] ? (~v + 33'd1) : v;
    endfunction

endpackage

// File: rtl/panda_risc_v_div.sv
// Radix-2 restoring divide/remainder unit on the dispatcher divider channel.
// Latency: 35 cycles from request handshake to result valid (1 cycle for divide-by-zero).
// Backpressure: one op in flight; result held in OUT until m_div_ready, request ready only in IDLE.
//
// Ports:
//   clk, rst                 core clock, async active-high reset
//   s_div_op_a / s_div_op_b  33-bit sign/zero-extended dividend / divisor
//   s_div_rem_sel            0 = quotient, 1 = remainder
//   s_div_rd_id              destination register, returned with the result
//   s_div_valid/s_div_ready  request handshake
//   m_div_res, m_div_rd_id   registered result and its RD index
//   m_div_valid/m_div_ready  result handshake toward write-back
module panda_risc_v_div
    import panda_risc_v_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [32:0] s_div_op_a,
    input  logic [32:0] s_div_op_b,
    input  logic        s_div_rem_sel,
    input  logic [4:0]  s_div_rd_id,
    input  logic        s_div_valid,
    output logic        s_div_ready,
    output logic [31:0] m_div_res,
    output logic [4:0]  m_div_rd_id,
    output logic        m_div_valid,
    input  logic        m_div_ready
);

    div_state_e  state;
    div_state_e  state_nxt;

    logic [5:0]  cnt;
    logic [32:0] dvd;        // dividend magnitude, shifted out MSB first
    logic [32:0] dvsr;       // divisor magnitude
    logic [32:0] prem;       // partial remainder
    logic [31:0] quo;        // quotient bits; bit 32 of a 33-bit quotient is always 0
    logic        qsign;
    logic        rsign;
    logic        rem_sel_q;

    logic        s_hs;
    logic        m_hs;
    logic        div_zero;
    logic        last_iter;

    logic [33:0] prem_sh;
    logic [32:0] prem_diff;
    logic        step_ge;
    logic [32:0] prem_nxt;

    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_res;

    assign s_hs      = s_div_valid & s_div_ready;
    assign m_hs      = m_div_valid & m_div_ready;
    assign div_zero  = (s_div_op_b == 33'd0);
    assign last_iter = (cnt == 6'(DIV_ITER_N - 1));

    // Restoring step. The shifted remainder is at most 2*|b|-1, so the compare
    // needs 34 bits, but when it succeeds the difference is below |b| and fits
    // in 33 bits; the modulo-2^33 subtraction is therefore exact where it is used.
    assign prem_sh   = {prem, dvd[32]};
    assign step_ge   = (prem_sh >= {1'b0, dvsr});
    assign prem_diff = prem_sh[32:0] - dvsr;
    assign prem_nxt  = step_ge ? prem_diff : prem_sh[32:0];

    // Sign fix-up; only the low 32 bits of each negation are architecturally visible.
    // The remainder is always below |b| <= 2^32, so its low 32 bits carry the value.
    assign quo_fix = qsign ? (~quo + 32'd1) : quo;
    assign rem_fix = rsign ? (~prem[31:0] + 32'd1) : prem[31:0];
    assign fix_res = rem_sel_q ? rem_fix : quo_fix;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            DIV_IDLE: begin
                if (s_hs) begin
                    state_nxt = div_zero ? DIV_OUT : DIV_CALC;
                end
            end
            DIV_CALC: begin
                if (last_iter) begin
                    state_nxt = DIV_FIX;
                end
            end
            DIV_FIX: begin
                state_nxt = DIV_OUT;
            end
            DIV_OUT: begin
                if (m_hs) begin
                    state_nxt = DIV_IDLE;
                end
            end
            default: begin
                state_nxt = DIV_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // Ready is held low while reset is asserted so nothing is accepted into an aborting unit.
    always_comb begin
        s_div_ready = (state == DIV_IDLE) & ~rst;
        m_div_valid = (state == DIV_OUT);
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= 6'd0;
            dvd         <= 33'd0;
            dvsr        <= 33'd0;
            prem        <= 33'd0;
            quo         <= 32'd0;
            qsign       <= 1'b0;
            rsign       <= 1'b0;
            rem_sel_q   <= 1'b0;
            m_div_res   <= 32'd0;
            m_div_rd_id <= 5'd0;
        end else begin
            unique case (state)
                DIV_IDLE: begin
                    if (s_hs) begin
                        cnt         <= 6'd0;
                        dvd         <= div_abs33(s_div_op_a);
                        dvsr        <= div_abs33(s_div_op_b);
                        prem        <= 33'd0;
                        quo         <= 32'd0;
                        qsign       <= s_div_op_a[32] ^ s_div_op_b[32];
                        rsign       <= s_div_op_a[32];
                        rem_sel_q   <= s_div_rem_sel;
                        m_div_rd_id <= s_div_rd_id;
                        // Divide-by-zero skips iteration and goes straight to OUT
                        if (div_zero) begin
                            m_div_res <= s_div_rem_sel ? s_div_op_a[31:0] : DIV_BY_ZERO_QUO;
                        end
                    end
                end
                DIV_CALC: begin
                    cnt  <= cnt + 6'd1;
                    dvd  <= {dvd[31:0], 1'b0};
                    prem <= prem_nxt;
                    quo  <= {quo[30:0], step_ge};
                end
                DIV_FIX: begin
                    m_div_res <= fix_res;
                end
                DIV_OUT: begin
                    // result registers hold until the write-back handshake
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_panda_risc_v_div.sv
module tb_panda_risc_v_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [32:0] s_div_op_a = '0;
    logic [32:0] s_div_op_b = '0;
    logic        s_div_rem_sel = 1'b0;
    logic [4:0]  s_div_rd_id = '0;
    logic        s_div_valid = 1'b0;
    logic        s_div_ready;
    logic [31:0] m_div_res;
    logic [4:0]  m_div_rd_id;
    logic        m_div_valid;
    logic        m_div_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    // Edges counted from the request-handshake edge to m_div_valid seen high:
    // valid in cycle t+35 means 34 edges after the edge closing cycle t.
    localparam int LAT_CALC = 34;
    localparam int LAT_ZERO = 0;

    always #5 clk = ~clk;

    panda_risc_v_div dut (
        .clk           (clk),
        .rst           (rst),
        .s_div_op_a    (s_div_op_a),
        .s_div_op_b    (s_div_op_b),
        .s_div_rem_sel (s_div_rem_sel),
        .s_div_rd_id   (s_div_rd_id),
        .s_div_valid   (s_div_valid),
        .s_div_ready   (s_div_ready),
        .m_div_res     (m_div_res),
        .m_div_rd_id   (m_div_rd_id),
        .m_div_valid   (m_div_valid),
        .m_div_ready   (m_div_ready)
    );

    // Drives one request, then waits for the result. lat = -1 if never accepted,
    // 999 if no result appeared in budget. With keep_junk set, s_div_valid stays
    // high after the handshake with a different request that must be ignored.
    task automatic issue(input logic [32:0] a, input logic [32:0] b, input logic sel,
                         input logic [4:0] rd, input logic keep_junk,
                         output int lat, output time t_hs);
        int w;
        lat  = -1;
        t_hs = 0;
        @(negedge clk);
        s_div_op_a    = a;
        s_div_op_b    = b;
        s_div_rem_sel = sel;
        s_div_rd_id   = rd;
        s_div_valid   = 1'b1;
        w = 0;
        while (!s_div_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!s_div_ready) begin
            s_div_valid = 1'b0;
            return;
        end
        @(posedge clk);
        t_hs = $time;
        #1;
        if (keep_junk) begin
            s_div_op_a    = 33'd55;
            s_div_op_b    = 33'd0;
            s_div_rem_sel = 1'b1;
            s_div_rd_id   = 5'd31;
        end else begin
            s_div_valid = 1'b0;
        end
        lat = 0;
        while (!m_div_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!m_div_valid) lat = 999;
    endtask

    task automatic drain();
        m_div_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (s_div_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got=%b exp=0", s_div_ready); end
        checks++; if (m_div_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got=%b exp=0", m_div_valid); end
        checks++; if (m_div_res !== 32'd0) begin errors++; $display("FAIL rst_res got=%h exp=0", m_div_res); end
        checks++; if (m_div_rd_id !== 5'd0) begin errors++; $display("FAIL rst_rd got=%0d exp=0", m_div_rd_id); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (s_div_ready !== 1'b1) begin errors++; $display("FAIL rst_rel_s_ready got=%b exp=1", s_div_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_res [2];
        int lat;
        time t;
        exp_res[0] = 32'd14;
        exp_res[1] = 32'd2;
        for (int i = 0; i < 2; i++) begin
            issue(33'd100, 33'd7, 1'(i), 5'd5, 1'b0, lat, t);
            checks++; if (lat != LAT_CALC) begin errors++; $display("FAIL basic%0d_lat got=%0d exp=%0d", i, lat, LAT_CALC); end
            checks++; if (m_div_res !== exp_res[i]) begin errors++; $display("FAIL basic%0d_res got=%h exp=%h", i, m_div_res, exp_res[i]); end
            checks++; if (m_div_rd_id !== 5'd5) begin errors++; $display("FAIL basic%0d_rd got=%0d exp=5", i, m_div_rd_id); end
            drain();
            checks++; if (s_div_ready !== 1'b1 || m_div_valid !== 1'b0) begin
                errors++; $display("FAIL basic%0d_post rdy=%b vld=%b exp rdy=1 vld=0", i, s_div_ready, m_div_valid);
            end
        end
    endtask

    task automatic test_signed();
        logic [32:0] va [4];
        logic [32:0] vb [4];
        logic [31:0] ve [4];
        int lat;
        time t;
        va[0] = 33'h1_FFFF_FFF9; vb[0] = 33'd2;          ve[0] = 32'hFFFF_FFFD; // -7/2 -> -3
        va[1] = 33'h1_FFFF_FFF9; vb[1] = 33'd2;          ve[1] = 32'hFFFF_FFFF; // -7%2 -> -1
        va[2] = 33'd7;           vb[2] = 33'h1_FFFF_FFFE; ve[2] = 32'hFFFF_FFFD; // 7/-2 -> -3
        va[3] = 33'd7;           vb[3] = 33'h1_FFFF_FFFE; ve[3] = 32'd1;         // 7%-2 -> 1
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], 1'(i % 2), 5'(i + 10), 1'b0, lat, t);
            checks++; if (lat != LAT_CALC) begin errors++; $display("FAIL signed%0d_lat got=%0d exp=%0d", i, lat, LAT_CALC); end
            checks++; if (m_div_res !== ve[i] || m_div_rd_id !== 5'(i + 10)) begin
                errors++; $display("FAIL signed%0d_res got=%h rd=%0d exp=%h rd=%0d", i, m_div_res, m_div_rd_id, ve[i], i + 10);
            end
            drain();
        end
    endtask

    task automatic test_unsigned();
        logic [32:0] vb [3];
        logic        vs [3];
        logic [31:0] ve [3];
        int lat;
        time t;
        vb[0] = 33'd1;            vs[0] = 1'b0; ve[0] = 32'hFFFF_FFFF;
        vb[1] = 33'd1;            vs[1] = 1'b1; ve[1] = 32'd0;
        vb[2] = 33'h0_8000_0000;  vs[2] = 1'b1; ve[2] = 32'h7FFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            issue({1'b0, 32'hFFFF_FFFF}, vb[i], vs[i], 5'd3, 1'b0, lat, t);
            checks++; if (lat != LAT_CALC || m_div_res !== ve[i]) begin
                errors++; $display("FAIL unsigned%0d got=%h lat=%0d exp=%h lat=%0d", i, m_div_res, lat, ve[i], LAT_CALC);
            end
            drain();
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] ve [2];
        int lat;
        time t;
        ve[0] = 32'hFFFF_FFFF;
        ve[1] = 32'd1234;
        for (int i = 0; i < 2; i++) begin
            issue(33'd1234, 33'd0, 1'(i), 5'd17, 1'b0, lat, t);
            checks++; if (lat != LAT_ZERO) begin errors++; $display("FAIL divzero%0d_lat got=%0d exp=%0d", i, lat, LAT_ZERO); end
            checks++; if (m_div_res !== ve[i] || m_div_rd_id !== 5'd17) begin
                errors++; $display("FAIL divzero%0d_res got=%h rd=%0d exp=%h rd=17", i, m_div_res, m_div_rd_id, ve[i]);
            end
            drain();
            checks++; if (s_div_ready !== 1'b1) begin errors++; $display("FAIL divzero%0d_post_rdy got=%b exp=1", i, s_div_ready); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] ve [2];
        int lat;
        time t;
        ve[0] = 32'h8000_0000;
        ve[1] = 32'd0;
        for (int i = 0; i < 2; i++) begin
            issue(33'h1_8000_0000, 33'h1_FFFF_FFFF, 1'(i), 5'd1, 1'b0, lat, t);
            checks++; if (lat != LAT_CALC || m_div_res !== ve[i]) begin
                errors++; $display("FAIL ovf%0d got=%h lat=%0d exp=%h lat=%0d", i, m_div_res, lat, ve[i], LAT_CALC);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        time t;
        logic bad_res, bad_rd, bad_vld, bad_rdy;
        bad_res = 1'b0; bad_rd = 1'b0; bad_vld = 1'b0; bad_rdy = 1'b0;
        m_div_ready = 1'b0;
        // a junk request stays asserted through CALC and OUT and must be ignored
        issue(33'd100, 33'd7, 1'b0, 5'd9, 1'b1, lat, t);
        checks++; if (lat != LAT_CALC || m_div_res !== 32'd14 || m_div_rd_id !== 5'd9) begin
            errors++; $display("FAIL bp_first got=%h rd=%0d lat=%0d exp=0000000e rd=9 lat=%0d", m_div_res, m_div_rd_id, lat, LAT_CALC);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (m_div_res !== 32'd14) bad_res = 1'b1;
            if (m_div_rd_id !== 5'd9) bad_rd = 1'b1;
            if (m_div_valid !== 1'b1) bad_vld = 1'b1;
            if (s_div_ready !== 1'b0) bad_rdy = 1'b1;
        end
        checks++; if (bad_res) begin errors++; $display("FAIL bp_res_stable got=%h exp=0000000e", m_div_res); end
        checks++; if (bad_rd) begin errors++; $display("FAIL bp_rd_stable got=%0d exp=9", m_div_rd_id); end
        checks++; if (bad_vld) begin errors++; $display("FAIL bp_vld_stable got=%b exp=1", m_div_valid); end
        checks++; if (bad_rdy) begin errors++; $display("FAIL bp_s_ready_low got=%b exp=0", s_div_ready); end
        s_div_valid = 1'b0;
        drain();
        checks++; if (s_div_ready !== 1'b1 || m_div_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release rdy=%b vld=%b exp rdy=1 vld=0", s_div_ready, m_div_valid);
        end
    endtask

    task automatic test_reset_abort();
        logic spurious;
        spurious = 1'b0;
        @(negedge clk);
        s_div_op_a    = 33'd100000;
        s_div_op_b    = 33'd3;
        s_div_rem_sel = 1'b0;
        s_div_rd_id   = 5'd22;
        s_div_valid   = 1'b1;
        @(posedge clk);
        #1;
        s_div_valid = 1'b0;
        // after 15 more edges the counter has reached iteration 15
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (m_div_valid !== 1'b0 || s_div_ready !== 1'b0) begin
            errors++; $display("FAIL abort_in_rst vld=%b rdy=%b exp vld=0 rdy=0", m_div_valid, s_div_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (s_div_ready !== 1'b1 || m_div_res !== 32'd0 || m_div_rd_id !== 5'd0) begin
            errors++; $display("FAIL abort_release rdy=%b res=%h rd=%0d exp rdy=1 res=0 rd=0", s_div_ready, m_div_res, m_div_rd_id);
        end
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (m_div_valid !== 1'b0) spurious = 1'b1;
        end
        checks++; if (spurious) begin errors++; $display("FAIL abort_spurious_result got=1 exp=0"); end
    endtask

    task automatic test_back_to_back();
        int lat0, lat1;
        time t0, t1;
        issue(33'd1000, 33'd10, 1'b0, 5'd7, 1'b0, lat0, t0);
        checks++; if (lat0 != LAT_CALC || m_div_res !== 32'd100) begin
            errors++; $display("FAIL b2b0 got=%h lat=%0d exp=00000064 lat=%0d", m_div_res, lat0, LAT_CALC);
        end
        drain();
        issue(33'd1000, 33'd10, 1'b1, 5'd8, 1'b0, lat1, t1);
        checks++; if (lat1 != LAT_CALC || m_div_res !== 32'd0 || m_div_rd_id !== 5'd8) begin
            errors++; $display("FAIL b2b1 got=%h rd=%0d lat=%0d exp=0 rd=8 lat=%0d", m_div_res, m_div_rd_id, lat1, LAT_CALC);
        end
        checks++; if ((t1 - t0) != 360) begin errors++; $display("FAIL b2b_interval got=%0t exp=360", t1 - t0); end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_unsigned();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
